// File: rtl/primus_fetch_ctrl.sv
// primus_fetch_ctrl: owns the program counter and sequences instruction fetch.
// Keeps at most one request outstanding to instruction memory (req/gnt, then rvalid).
// Hands each fetched word to decode over a valid/ready pair.
// A redirect that arrives while a response is in flight marks that response for discard.

module primus_fetch_ctrl #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    output logic            imem_req_o,
    input  logic            imem_gnt_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            id_ready_i,
    output logic            id_valid_o,
    output logic [XLEN-1:0] ir_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] npc_o
);

    localparam logic [XLEN-1:0] NOP  = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0] STEP = XLEN'(4);

    typedef enum logic [1:0] {StBoot, StReq, StWait, StHold} state_e;

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] ir_q;
    logic [XLEN-1:0] pc_out_q;
    logic            discard_q;
    logic            id_valid_q;

    logic [XLEN-1:0] redirect_target;
    logic            unused_redirect_lsbs;

    // Targets are word aligned; the two low bits of the redirect PC carry no information.
    assign redirect_target      = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    // A redirect withdraws the request in the same cycle, so an old address is never granted.
    assign imem_req_o  = (state_q == StReq) && !redirect_i;
    assign imem_addr_o = pc_q;

    assign id_valid_o  = id_valid_q;
    assign ir_o        = ir_q;
    assign pc_o        = pc_out_q;
    assign npc_o       = pc_out_q + STEP;

    // Fetch sequencer: PC update, discard tracking and decode-side output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StBoot;
            pc_q       <= RESET_PC;
            ir_q       <= NOP;
            pc_out_q   <= RESET_PC;
            discard_q  <= 1'b0;
            id_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StBoot: begin
                    state_q <= StReq;
                end

                StReq: begin
                    if (redirect_i) begin
                        pc_q <= redirect_target;
                    end else if (imem_gnt_i) begin
                        state_q <= StWait;
                    end
                end

                StWait: begin
                    if (redirect_i) begin
                        pc_q <= redirect_target;
                    end
                    if (imem_rvalid_i) begin
                        // Data fetched for a superseded PC is dropped and fetch restarts.
                        if (discard_q || redirect_i) begin
                            discard_q <= 1'b0;
                            state_q   <= StReq;
                        end else begin
                            ir_q       <= imem_rdata_i;
                            pc_out_q   <= pc_q;
                            id_valid_q <= 1'b1;
                            state_q    <= StHold;
                        end
                    end else if (redirect_i) begin
                        discard_q <= 1'b1;
                    end
                end

                StHold: begin
                    // Redirect takes priority over a decode accept.
                    if (redirect_i) begin
                        id_valid_q <= 1'b0;
                        pc_q       <= redirect_target;
                        state_q    <= StReq;
                    end else if (id_ready_i) begin
                        id_valid_q <= 1'b0;
                        pc_q       <= pc_q + STEP;
                        state_q    <= StReq;
                    end
                end

                default: begin
                    state_q <= StBoot;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_primus_fetch_ctrl.sv
// Testbench for primus_fetch_ctrl.
// A transaction-level model predicts the decode-side outputs and the memory-side request
// on every cycle. Directed phases pin the model with literal values. A random phase
// exercises redirects, backpressure, slow memory and resets.

module tb_primus_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          LIMIT  = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_o;
    logic        imem_gnt_i;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_ready_i;
    logic        id_valid_o;
    logic [31:0] ir_o;
    logic [31:0] pc_o;
    logic [31:0] npc_o;

    int checks = 0;
    int errors = 0;

    // Stimulus knobs, written by the main sequence and read by the driver.
    bit          rnd_mode    = 1'b0;
    int          gnt_wait    = 0;
    int          dly_cfg     = 0;
    bit          rdy_cfg     = 1'b1;
    bit          force_redir = 1'b0;
    logic [31:0] force_tgt   = '0;

    // Memory responder state.
    bit          mem_pending = 1'b0;
    logic [31:0] mem_addr    = '0;
    int          mem_cnt     = 0;
    int          req_age     = 0;

    // Reference model state: requests in flight, plus what decode should currently see.
    typedef struct packed {
        logic [31:0] addr;
        bit          stale;
    } flight_t;

    flight_t     q[$];
    bit          m_boot = 1'b1;
    bit          m_req  = 1'b0;
    bit          m_show = 1'b0;
    logic [31:0] m_pc   = RST_PC;
    logic [31:0] m_pco  = RST_PC;
    logic [31:0] m_ir   = NOP;

    always #5 clk = ~clk;

    primus_fetch_ctrl #(
        .XLEN    (32),
        .RESET_PC(RST_PC)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .imem_req_o   (imem_req_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_addr_o  (imem_addr_o),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .id_ready_i   (id_ready_i),
        .id_valid_o   (id_valid_o),
        .ir_o         (ir_o),
        .pc_o         (pc_o),
        .npc_o        (npc_o)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!id_valid_o && n < LIMIT);
        checks++;
        if (!id_valid_o) begin
            errors++;
            $display("FAIL wait_valid: got timeout expected id_valid_o=1");
        end
    endtask

    task automatic wait_req(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!imem_req_o && n < LIMIT);
        checks++;
        if (!imem_req_o) begin
            errors++;
            $display("FAIL wait_req: got timeout expected imem_req_o=1");
        end
    endtask

    // Driver: decode-side inputs at +1, memory responses and grants at +2 after each rising edge.
    initial begin
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        id_ready_i    = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (force_redir) begin
                redirect_i    = 1'b1;
                redirect_pc_i = force_tgt;
                force_redir   = 1'b0;
            end else if (rnd_mode && $urandom_range(99) < 12) begin
                redirect_i    = 1'b1;
                redirect_pc_i = ($urandom_range(3) == 0) ?
                                (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom();
            end else begin
                redirect_i = 1'b0;
            end
            id_ready_i = rnd_mode ? ($urandom_range(99) < 60) : rdy_cfg;
            #1;
            imem_rvalid_i = 1'b0;
            if (mem_pending) begin
                if (mem_cnt == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = mem_word(mem_addr);
                    mem_pending   = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end else if (rnd_mode && $urandom_range(99) < 5) begin
                // Stray response with no request outstanding; the DUT must ignore it.
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = $urandom();
            end
            req_age    = imem_req_o ? req_age + 1 : 0;
            imem_gnt_i = 1'b0;
            if (imem_req_o && !mem_pending &&
                (rnd_mode ? ($urandom_range(99) < 60) : (req_age > gnt_wait))) begin
                imem_gnt_i  = 1'b1;
                mem_pending = 1'b1;
                mem_addr    = imem_addr_o;
                mem_cnt     = rnd_mode ? int'($urandom_range(3)) : dly_cfg;
            end
        end
    end

    // Compare process: check outputs against the model, then advance the model over the coming edge.
    initial begin
        flight_t     it;
        logic [31:0] tgt;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("m_rst_req", 32'(imem_req_o), 32'd0);
                chk("m_rst_valid", 32'(id_valid_o), 32'd0);
                chk("m_rst_addr", imem_addr_o, RST_PC);
                chk("m_rst_pc", pc_o, RST_PC);
                chk("m_rst_ir", ir_o, NOP);
                q.delete();
                m_boot = 1'b1;
                m_req  = 1'b0;
                m_show = 1'b0;
                m_pc   = RST_PC;
            end else begin
                chk("m_valid", 32'(id_valid_o), 32'(m_show));
                if (m_show) begin
                    chk("m_ir", ir_o, m_ir);
                    chk("m_pc", pc_o, m_pco);
                    chk("m_npc", npc_o, m_pco + 32'd4);
                end
                chk("m_req", 32'(imem_req_o), 32'(m_req && !redirect_i));
                if (m_req && !redirect_i) chk("m_addr", imem_addr_o, m_pc);

                tgt = redirect_pc_i & ~32'h3;
                if (m_boot) begin
                    m_boot = 1'b0;
                    m_req  = 1'b1;
                end else if (m_show) begin
                    if (redirect_i) begin
                        m_show = 1'b0;
                        m_req  = 1'b1;
                        m_pc   = tgt;
                    end else if (id_ready_i) begin
                        m_show = 1'b0;
                        m_req  = 1'b1;
                        m_pc   = m_pco + 32'd4;
                    end
                end else if (m_req) begin
                    if (redirect_i) begin
                        m_pc = tgt;
                    end else if (imem_gnt_i) begin
                        q.push_back('{addr: m_pc, stale: 1'b0});
                        m_req = 1'b0;
                    end
                end else if (q.size() != 0) begin
                    if (redirect_i) begin
                        m_pc        = tgt;
                        q[0].stale  = 1'b1;
                    end
                    if (imem_rvalid_i) begin
                        it = q.pop_front();
                        if (it.stale) begin
                            m_req = 1'b1;
                        end else begin
                            m_show = 1'b1;
                            m_pco  = it.addr;
                            m_ir   = mem_word(it.addr);
                        end
                    end
                end
            end
        end
    end

    // Main sequence: directed scenarios with literal expectations, then random traffic.
    initial begin
        int n;
        bit saw;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_addr", imem_addr_o, 32'hFFFF_FFFC);
        chk("rst_valid", 32'(id_valid_o), 32'd0);
        chk("rst_ir", ir_o, 32'h0000_0013);
        chk("rst_pc", pc_o, 32'hFFFF_FFFC);
        chk("rst_npc", npc_o, 32'h0000_0000);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Zero-wait memory, decode always ready; wrap from 0xFFFF_FFFC to 0.
        @(negedge clk);
        chk("boot_no_req", 32'(imem_req_o), 32'd0);
        @(negedge clk);
        chk("first_req", 32'(imem_req_o), 32'd1);
        chk("first_addr", imem_addr_o, 32'hFFFF_FFFC);
        wait_valid(n);
        chk("first_latency", 32'(n), 32'd2);
        chk("first_pc", pc_o, 32'hFFFF_FFFC);
        chk("first_npc", npc_o, 32'h0000_0000);
        chk("first_ir", ir_o, mem_word(32'hFFFF_FFFC));
        wait_req(n);
        chk("wrap_addr", imem_addr_o, 32'h0);
        wait_valid(n);
        chk("pc0", pc_o, 32'h0);
        chk("npc0", npc_o, 32'h4);

        // Decode backpressure for five cycles.
        rdy_cfg = 1'b0;
        wait_req(n);
        chk("seq_addr", imem_addr_o, 32'h4);
        wait_valid(n);
        chk("seq_pc", pc_o, 32'h4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(id_valid_o), 32'd1);
            chk("hold_req", 32'(imem_req_o), 32'd0);
            chk("hold_pc", pc_o, 32'h4);
            chk("hold_ir", ir_o, mem_word(32'h4));
        end

        // Slow memory: grant after 3 waiting cycles, response 4 cycles after grant.
        gnt_wait = 3;
        dly_cfg  = 3;
        rdy_cfg  = 1'b1;
        wait_req(n);
        chk("after_hold_addr", imem_addr_o, 32'h8);
        n = 0;
        while (imem_req_o && n < LIMIT) begin
            chk("slow_addr_stable", imem_addr_o, 32'h8);
            n++;
            @(negedge clk);
        end
        chk("slow_req_cycles", 32'(n), 32'd4);
        wait_valid(n);
        chk("slow_pc", pc_o, 32'h8);
        chk("slow_ir", ir_o, mem_word(32'h8));
        @(negedge clk);
        chk("slow_single_pulse", 32'(id_valid_o), 32'd0);

        // Redirect while the response for 0xC is in flight.
        n = 0;
        while (!(imem_req_o && imem_gnt_i) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("wait_grant_addr", imem_addr_o, 32'hC);
        force_tgt   = 32'h100;
        force_redir = 1'b1;
        saw = 1'b0;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
            if (id_valid_o) saw = 1'b1;
        end while (!imem_req_o && n < LIMIT);
        chk("wait_drop_valid", 32'(saw), 32'd0);
        chk("wait_redir_addr", imem_addr_o, 32'h100);
        gnt_wait = 0;
        dly_cfg  = 0;
        wait_valid(n);
        chk("wait_redir_pc", pc_o, 32'h100);

        // Redirect and decode-ready in the same HOLD cycle: redirect wins.
        rdy_cfg = 1'b0;
        wait_req(n);
        chk("seq_after_redir", imem_addr_o, 32'h104);
        wait_valid(n);
        chk("hold2_pc", pc_o, 32'h104);
        force_tgt   = 32'h203;
        force_redir = 1'b1;
        rdy_cfg     = 1'b1;
        wait_req(n);
        chk("hold_redir_addr", imem_addr_o, 32'h200);
        wait_valid(n);
        chk("hold_redir_pc", pc_o, 32'h200);

        // Reset in the middle of a WAIT; the late response must be ignored.
        dly_cfg = 3;
        wait_req(n);
        chk("pre_rst_gnt", 32'(imem_gnt_i), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_req", 32'(imem_req_o), 32'd0);
        chk("async_rst_addr", imem_addr_o, 32'hFFFF_FFFC);
        chk("async_rst_valid", 32'(id_valid_o), 32'd0);
        chk("async_rst_ir", ir_o, 32'h0000_0013);
        chk("async_rst_pc", pc_o, 32'hFFFF_FFFC);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_req(n);
        chk("restart_addr", imem_addr_o, 32'hFFFF_FFFC);
        wait_valid(n);
        chk("restart_pc", pc_o, 32'hFFFF_FFFC);
        chk("restart_ir", ir_o, mem_word(32'hFFFF_FFFC));

        // Random traffic with occasional resets.
        rnd_mode = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            if ($urandom_range(299) == 0) begin
                #3 rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected normal end");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
